// File: rtl/fft_frame_buffer_pkg.sv
// Shared definitions for the FIR -> FFT ping-pong frame buffer.
// The sample width and frame length here are the defaults that the filter and the FFT also use.
package fft_frame_buffer_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_FRAME_LEN = 256;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  function automatic logic bank_writable(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

  function automatic logic bank_readable(input bank_state_t s);
    return (s == BANK_FULL) || (s == BANK_DRAINING);
  endfunction

endpackage

// File: rtl/fft_frame_buffer_ram.sv
// Simple dual-port RAM that holds both frame banks, addressed {bank, ptr}.
// It has one write port and one registered read port with a read enable.
module frame_bank_ram
  import fft_frame_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = $clog2(2 * DEF_FRAME_LEN)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: the filter fills one bank while the other bank streams to the FFT.
// A 2-entry skid after the RAM keeps the output at one sample per cycle under valid/ready.
module fft_frame_buffer
  import fft_frame_buffer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);

  bank_state_t       r_bank_state      [2];
  bank_state_t       w_bank_state_next [2];
  logic              r_wr_bank;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_rd_iss_bank;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_rd_bank;
  logic              r_pend;
  logic              r_pend_last;
  logic [ADDR_W-1:0] r_pend_index;
  logic [DATA_W-1:0] r_skid_data  [2];
  logic [ADDR_W-1:0] r_skid_index [2];
  logic              r_skid_last  [2];
  logic              r_skid_head;
  logic [1:0]        r_skid_count;
  logic              r_frame_done;
  logic              r_overrun;

  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_wr_en;
  logic              w_wr_last;
  logic              w_pop;
  logic              w_free;
  logic              w_credit;
  logic              w_rd_issue;
  logic              w_rd_iss_last;
  logic              w_skid_tail;

  assign in_ready      = bank_writable(r_bank_state[r_wr_bank]);
  assign w_wr_en       = in_valid && in_ready;
  assign w_wr_last     = w_wr_en && (r_wr_ptr == LAST_PTR);
  assign w_pop         = (r_skid_count != 2'd0) && out_ready;
  assign w_free        = w_pop && r_skid_last[r_skid_head];
  // A read may issue only if the skid still has room once this cycle's pop and the in-flight read land.
  assign w_credit      = ({1'b0, r_skid_count} + {2'b00, r_pend}) <= ({2'b00, w_pop} + 3'd1);
  assign w_rd_issue    = bank_readable(r_bank_state[r_rd_iss_bank]) && w_credit;
  assign w_rd_iss_last = w_rd_issue && (r_rd_ptr == LAST_PTR);
  assign w_skid_tail   = r_skid_head ^ r_skid_count[0];

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_bank_state_next[b] = r_bank_state[b];
      if (w_wr_en && (r_wr_bank == 1'(b)))
        w_bank_state_next[b] = w_wr_last ? BANK_FULL : BANK_FILLING;
      if (w_rd_issue && (r_rd_iss_bank == 1'(b)) && (r_bank_state[b] == BANK_FULL))
        w_bank_state_next[b] = BANK_DRAINING;
      if (w_free && (r_rd_bank == 1'(b)))
        w_bank_state_next[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bank_state[0] <= BANK_EMPTY;
      r_bank_state[1] <= BANK_EMPTY;
    end else begin
      r_bank_state[0] <= w_bank_state_next[0];
      r_bank_state[1] <= w_bank_state_next[1];
    end
  end

  // Reads may run ahead into the next bank, so the issue bank is tracked apart from the drain owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_bank     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_iss_bank <= 1'b0;
      r_rd_ptr      <= '0;
      r_rd_bank     <= 1'b0;
      r_pend        <= 1'b0;
      r_pend_last   <= 1'b0;
      r_pend_index  <= '0;
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_wr_last) r_wr_bank <= ~r_wr_bank;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      if (w_rd_iss_last) r_rd_iss_bank <= ~r_rd_iss_bank;
      if (w_free) r_rd_bank <= ~r_rd_bank;
      r_pend       <= w_rd_issue;
      r_pend_last  <= w_rd_iss_last;
      r_pend_index <= r_rd_ptr;
      r_frame_done <= w_free;
      if (in_valid && !in_ready) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        r_skid_data[k]  <= '0;
        r_skid_index[k] <= '0;
        r_skid_last[k]  <= 1'b0;
      end
      r_skid_head  <= 1'b0;
      r_skid_count <= 2'd0;
    end else begin
      if (r_pend) begin
        r_skid_data[w_skid_tail]  <= w_ram_rdata;
        r_skid_index[w_skid_tail] <= r_pend_index;
        r_skid_last[w_skid_tail]  <= r_pend_last;
      end
      if (w_pop) r_skid_head <= ~r_skid_head;
      r_skid_count <= r_skid_count + 2'(r_pend) - 2'(w_pop);
    end
  end

  frame_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr ({r_wr_bank, r_wr_ptr}),
    .i_wr_data (in_data),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr ({r_rd_iss_bank, r_rd_ptr}),
    .o_rd_data (w_ram_rdata)
  );

  assign out_valid  = (r_skid_count != 2'd0);
  assign out_data   = r_skid_data[r_skid_head];
  assign out_index  = r_skid_index[r_skid_head];
  assign out_last   = r_skid_last[r_skid_head];
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: reset, single frame, backpressure, overrun,
// simultaneous fill/drain completion and mid-frame reset, with an output scoreboard.
module tb_fft_frame_buffer;

  localparam int DW = 32;
  localparam int FL = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic          frame_done;
  logic          overrun;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_frame_done = 0;

  logic [31:0] exp_q[$];
  int          exp_idx = 0;
  bit          rand_ready = 0;

  logic          stall_prev = 1'b0;
  logic          last_hs_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] prev_index = '0;
  logic          prev_last = 1'b0;

  fft_frame_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 32'(i);
      expect_eq("in_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(base + 32'(i));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    expect_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Output scoreboard, sampled mid-cycle: each negedge sees what the next rising edge will consume.
  always @(negedge clk) begin
    logic [31:0] exp_d;
    if (!rst) begin
      exp_idx      = 0;
      stall_prev   = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        expect_eq("hold_valid", 32'(out_valid), 32'd1);
        expect_eq("hold_data", out_data, prev_data);
        expect_eq("hold_index", 32'(out_index), 32'(prev_index));
        expect_eq("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (frame_done || last_hs_prev)
        expect_eq("frame_done_timing", 32'(frame_done), 32'(last_hs_prev));
      if (frame_done) n_frame_done++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          expect_eq("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          exp_d = exp_q.pop_front();
          $display("out idx=%0d data=%h last=%0d", out_index, out_data, out_last);
          expect_eq("out_data", out_data, exp_d);
          expect_eq("out_index", 32'(out_index), 32'(exp_idx));
          expect_eq("out_last", 32'(out_last), 32'(exp_idx == FL - 1));
          exp_idx = (exp_idx + 1) % FL;
        end
      end
      stall_prev   = out_valid && !out_ready;
      last_hs_prev = out_valid && out_ready && out_last;
      prev_data    = out_data;
      prev_index   = out_index;
      prev_last    = out_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held three cycles with random inputs.
    rst = 1'b0;
    repeat (3) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      expect_eq("rst_out_valid", 32'(out_valid), 32'd0);
      expect_eq("rst_out_data", out_data, 32'd0);
      expect_eq("rst_out_index", 32'(out_index), 32'd0);
      expect_eq("rst_out_last", 32'(out_last), 32'd0);
      expect_eq("rst_frame_done", 32'(frame_done), 32'd0);
      expect_eq("rst_overrun", 32'(overrun), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    expect_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
    expect_eq("post_rst_overrun", 32'(overrun), 32'd0);
    expect_eq("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Single frame with out_ready held high; check fill latency.
    out_ready = 1'b1;
    send_frame(32'h3F80_0000, FL);
    expect_eq("lat_n_valid", 32'(out_valid), 32'd0);
    tick();
    expect_eq("lat_n1_valid", 32'(out_valid), 32'd0);
    tick();
    expect_eq("lat_n2_valid", 32'(out_valid), 32'd1);
    expect_eq("lat_n2_index", 32'(out_index), 32'd0);
    expect_eq("lat_n2_data", out_data, 32'h3F80_0000);
    wait_drain("drain_single", 400);
    tick();
    tick();
    expect_eq("frame_done_cnt_single", 32'(n_frame_done), 32'd1);

    // Same frame under random backpressure.
    rand_ready = 1;
    send_frame(32'h3F80_0000, FL);
    wait_drain("drain_backpressure", 2000);
    rand_ready = 0;
    out_ready  = 1'b1;
    tick();
    tick();
    expect_eq("frame_done_cnt_bp", 32'(n_frame_done), 32'd2);

    // Overrun: both banks full, 513th sample dropped.
    out_ready = 1'b0;
    send_frame(32'h5000_0000, 2 * FL);
    expect_eq("full_in_ready", 32'(in_ready), 32'd0);
    expect_eq("overrun_before", 32'(overrun), 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h5000_0200;
    tick();
    in_valid = 1'b0;
    expect_eq("overrun_set", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    repeat (2 * FL - 1) tick();
    expect_eq("b2b_remaining", 32'(exp_q.size()), 32'd1);
    tick();
    expect_eq("b2b_done", 32'(exp_q.size()), 32'd0);
    tick();
    tick();
    expect_eq("frame_done_cnt_ovr", 32'(n_frame_done), 32'd4);
    expect_eq("ovr_in_ready_after", 32'(in_ready), 32'd1);
    expect_eq("overrun_sticky", 32'(overrun), 32'd1);

    // Frame-1 last write on the same edge as frame-0 out_last handshake.
    out_ready = 1'b0;
    send_frame(32'h6000_0000, FL);
    send_frame(32'h6100_0000, FL - 1);
    out_ready = 1'b1;
    repeat (FL - 1) tick();
    expect_eq("sim_out_last", 32'(out_last), 32'd1);
    expect_eq("sim_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 32'h6100_00FF;
    exp_q.push_back(32'h6100_00FF);
    tick();
    in_valid = 1'b0;
    expect_eq("sim_frame_done", 32'(frame_done), 32'd1);
    expect_eq("sim_in_ready_after", 32'(in_ready), 32'd1);
    send_frame(32'h6200_0000, FL);
    wait_drain("drain_sim", 1200);
    tick();
    tick();
    expect_eq("frame_done_cnt_sim", 32'(n_frame_done), 32'd7);

    // Mid-frame reset discards the partial frame.
    send_frame(32'h7000_0000, 100);
    rst = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b1;
    expect_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    repeat (3) begin
      tick();
      expect_eq("mid_rst_idle_valid", 32'(out_valid), 32'd0);
      expect_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    end
    send_frame(32'h7100_0000, FL);
    wait_drain("drain_mid_rst", 400);
    tick();
    tick();
    expect_eq("frame_done_cnt_mid_rst", 32'(n_frame_done), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
